booth_ln_series: RTL and testbench

//  Computes ln(1+x) with an alternating Taylor series: x - x^2/2 + x^3/3 - ...
//  It is the inverse partner of the Booth-based exp(x) Taylor block.
//  A sequential radix-2 Booth multiplier is shared for both jobs: raising

---
 rtl/booth_ln_series.sv | 177 +++++++++++++++++
 tb/tb_booth_ln_series.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/booth_ln_series.sv
// ln(1+x) by alternating Taylor series, using one shared sequential radix-2 Booth multiplier.
// Optional define LN_ROUND_EN: round half up on power truncation and term scaling instead of truncating.
module booth_ln_series #(
  parameter int N_TERMS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] x_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] ln_out
);

  typedef enum logic [2:0] {IDLE, MUL_POW, MUL_TERM, ACC, DONE} state_t;

`ifdef LN_ROUND_EN
  localparam logic        POW_RND  = 1'b1;
  localparam logic [31:0] TERM_RND = 32'h0000_2000;
`else
  localparam logic        POW_RND  = 1'b0;
  localparam logic [31:0] TERM_RND = 32'h0000_0000;
`endif

  function automatic logic [15:0] recip(input logic [4:0] n);
    case (n)
      5'd2:    return 16'h4000;
      5'd3:    return 16'h2AAB;
      5'd4:    return 16'h2000;
      5'd5:    return 16'h199A;
      5'd6:    return 16'h1555;
      5'd7:    return 16'h1249;
      5'd8:    return 16'h1000;
      5'd9:    return 16'h0E39;
      5'd10:   return 16'h0CCD;
      5'd11:   return 16'h0BA3;
      5'd12:   return 16'h0AAB;
      5'd13:   return 16'h09D9;
      5'd14:   return 16'h0925;
      5'd15:   return 16'h0889;
      5'd16:   return 16'h0800;
      default: return 16'h0000;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [15:0] p_q, p_d, xr_q, xr_d, q_q, q_d, m_q, m_d;
  logic [31:0] acc_q, acc_d, t_q, t_d, ln_out_q, ln_out_d;
  logic [16:0] a_q, a_d;
  logic [4:0]  n_q, n_d, cnt_q, cnt_d;
  logic        q1_q, q1_d, busy_q, busy_d, done_q, done_d;

  logic [16:0] m_ext, a_sum, a_sh, pow_wide;
  logic [15:0] q_sh, pow_next;
  logic [31:0] prod, t_sh;

  // One Booth step: add/sub on {Q0,Q-1}, then arithmetic shift of {A,Q,Q-1}.
  always_comb begin
    m_ext = {m_q[15], m_q};
    case ({q_q[0], q1_q})
      2'b01:   a_sum = a_q + m_ext;
      2'b10:   a_sum = a_q - m_ext;
      default: a_sum = a_q;
    endcase
    a_sh = {a_sum[16], a_sum[16:1]};
    q_sh = {a_sum[0], q_q[15:1]};
    prod = {a_sh[15:0], q_sh};
    pow_wide = prod[31:15] + {16'd0, POW_RND & prod[14]};
    if (pow_wide[16] != pow_wide[15]) pow_next = pow_wide[16] ? 16'h8000 : 16'h7FFF;
    else                              pow_next = pow_wide[15:0];
    t_sh = $signed(t_q + TERM_RND) >>> 14;
  end

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    xr_d     = xr_q;
    q_d      = q_q;
    m_d      = m_q;
    acc_d    = acc_q;
    t_d      = t_q;
    ln_out_d = ln_out_q;
    a_d      = a_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    q1_d     = q1_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          p_d     = x_in;
          xr_d    = x_in;
          acc_d   = {{15{x_in[15]}}, x_in, 1'b0};
          n_d     = 5'd2;
          busy_d  = 1'b1;
          state_d = (N_TERMS == 1) ? DONE : MUL_POW;
        end
      end
      MUL_POW, MUL_TERM: begin
        // cnt==0 marks the setup cycle on entry to either multiply state.
        if (cnt_q == 5'd0) begin
          a_d   = 17'd0;
          q1_d  = 1'b0;
          q_d   = p_q;
          m_d   = (state_q == MUL_POW) ? xr_q : recip(n_q);
          cnt_d = 5'd16;
        end else begin
          a_d   = a_sh;
          q_d   = q_sh;
          q1_d  = q_q[0];
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            if (state_q == MUL_POW) begin
              p_d     = pow_next;
              state_d = MUL_TERM;
            end else begin
              t_d     = prod;
              state_d = ACC;
            end
          end
        end
      end
      ACC: begin
        acc_d   = n_q[0] ? acc_q + t_sh : acc_q - t_sh;
        n_d     = n_q + 5'd1;
        state_d = (n_q == 5'(N_TERMS)) ? DONE : MUL_POW;
      end
      DONE: begin
        ln_out_d = acc_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      p_q      <= '0;
      xr_q     <= '0;
      q_q      <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      t_q      <= '0;
      ln_out_q <= '0;
      a_q      <= '0;
      n_q      <= '0;
      cnt_q    <= '0;
      q1_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      xr_q     <= xr_d;
      q_q      <= q_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      t_q      <= t_d;
      ln_out_q <= ln_out_d;
      a_q      <= a_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      q1_q     <= q1_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign ln_out = ln_out_q;

endmodule

// File: tb/tb_booth_ln_series.sv
// Self-checking bench for booth_ln_series: randomized x against an arithmetic series model,
// plus latency, busy/start-ignore, reset-abort and single-term instance checks.
module tb_booth_ln_series;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] x_in = '0;
  logic        busy, done;
  logic [31:0] ln_out;

  logic        start1 = 1'b0;
  logic [15:0] x1 = '0;
  logic        busy1, done1;
  logic [31:0] ln1;

  int total_checks = 0;
  int passed_checks = 0;

  localparam int RECIP [0:14] = '{16'h4000, 16'h2AAB, 16'h2000, 16'h199A, 16'h1555,
                                  16'h1249, 16'h1000, 16'h0E39, 16'h0CCD, 16'h0BA3,
                                  16'h0AAB, 16'h09D9, 16'h0925, 16'h0889, 16'h0800};
`ifdef LN_ROUND_EN
  localparam longint P_RND = 64'sd16384;
  localparam longint T_RND = 64'sd8192;
`else
  localparam longint P_RND = 64'sd0;
  localparam longint T_RND = 64'sd0;
`endif

  booth_ln_series #(.N_TERMS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in),
    .busy(busy), .done(done), .ln_out(ln_out)
  );

  booth_ln_series #(.N_TERMS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .x_in(x1),
    .busy(busy1), .done(done1), .ln_out(ln1)
  );

  always #5 clk = ~clk;

  // Series reference: powers in Q1.15 with saturation, terms scaled to Q16.16, 32-bit wrapping sum.
  function automatic logic [31:0] refLn(input logic [15:0] x, input int nterms);
    longint xv, p, acc, prod, t, d;
    xv  = longint'($signed(x));
    p   = xv;
    acc = xv * 2;
    for (int n = 2; n <= nterms; n++) begin
      prod = p * xv;
      p = (prod + P_RND) >>> 15;
      if (p > 32767) p = 32767;
      else if (p < -32768) p = -32768;
      t = p * longint'(RECIP[n-2]);
      d = (t + T_RND) >>> 14;
      acc = (n % 2 == 1) ? acc + d : acc - d;
    end
    return acc[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got === exp) passed_checks++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Runs one request on the 8-term instance; optionally pokes start again while busy.
  task automatic applyStimulus(input logic [15:0] x, input int poke_at, input logic [15:0] poke_x,
                               output logic [31:0] result);
    int cycles;
    logic [31:0] exp;
    exp = refLn(x, 8);
    @(negedge clk);
    start = 1'b1;
    x_in  = x;
    @(posedge clk); #1;
    start = 1'b0;
    x_in  = 16'($urandom);
    checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
    cycles = 0;
    while (!done && cycles < 400) begin
      if (cycles == poke_at) begin
        start = 1'b1;
        x_in  = poke_x;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    checkOutput("latency", cycles, 32'd246);
    checkOutput("ln_out", ln_out, exp);
    checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
    result = ln_out;
    @(posedge clk); #1;
    checkOutput("done_single", {31'd0, done}, 32'd0);
    checkOutput("ln_out_held", ln_out, exp);
    checkOutput("idle_not_busy", {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] within3(input logic [31:0] got, input logic [31:0] target);
    int diff;
    diff = int'(got) - int'(target);
    return (diff >= -3 && diff <= 3) ? 32'd1 : 32'd0;
  endfunction

  initial begin
    logic [31:0] res;
    logic [15:0] rx;
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_ln_out", ln_out, 32'd0);
    checkOutput("reset_ln1", ln1, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(16'h0000, -1, 16'h0000, res);
    checkOutput("zero_result", res, 32'h0000_0000);

    applyStimulus(16'h4000, -1, 16'h0000, res);
    checkOutput("half_tolerance", within3(res, 32'h0000_67C2), 32'd1);

    applyStimulus(16'hC000, -1, 16'h0000, res);
    checkOutput("neg_half_tolerance", within3(res, 32'hFFFF_4EA8), 32'd1);

    applyStimulus(16'h8000, -1, 16'h0000, res);
    applyStimulus(16'h7FFF, -1, 16'h0000, res);

    applyStimulus(16'h4000, 50, 16'h2000, res);

    for (int i = 0; i < 6; i++) begin
      rx = 16'($urandom_range(0, 16'h8000)) - 16'h4000;
      applyStimulus(rx, -1, 16'h0000, res);
    end
    for (int i = 0; i < 3; i++) begin
      rx = 16'($urandom);
      applyStimulus(rx, -1, 16'h0000, res);
    end

    // Reset in the middle of the first term multiply, then recover.
    @(negedge clk);
    start = 1'b1;
    x_in  = 16'h2000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_ln_out", ln_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'h4000, -1, 16'h0000, res);
    checkOutput("after_abort", res, refLn(16'h4000, 8));

    // Single-term instance: done one edge after accept.
    @(negedge clk);
    start1 = 1'b1;
    x1     = 16'h4000;
    @(posedge clk); #1;
    start1 = 1'b0;
    checkOutput("n1_busy", {31'd0, busy1}, 32'd1);
    checkOutput("n1_done_early", {31'd0, done1}, 32'd0);
    @(posedge clk); #1;
    checkOutput("n1_done", {31'd0, done1}, 32'd1);
    checkOutput("n1_ln_out", ln1, 32'h0000_8000);
    checkOutput("n1_model", ln1, refLn(16'h4000, 1));
    @(posedge clk); #1;
    checkOutput("n1_done_single", {31'd0, done1}, 32'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
